data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the data-memory interface. Accepts load/store requests from the execute/memory pipeline.
//  Performs store lane replication and byte-strobe generation into an internal word-wide data RAM.
//  Returns the raw addressed 32-bit word to the memory stage, which does load extraction and sign extension.
//  Emulates a slow memory with programmable wait states, behind a valid/ready handshake on both channels.
// PARAMETERS
//  AW           10           word-index width; RAM depth = 2**AW words (4 KiB default)
//  WAIT_CYCLES  1            extra cycles between request accept and RAM access (0..15)
//  BASE_ADDR    32'h0000_0000 byte address of word 0; addresses outside [BASE, BASE+4*2**AW) are errors
// PORTS
//  clk         in   1   clock, all state on posedge
//  resetn      in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept this cycle
//  req_wr      in   1   1 = store, 0 = load
//  req_size    in   2   0 byte, 1 half, 2 word; 3 reserved (error)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid  out  1   response present
//  resp_ready  in   1   memory stage consumes response
//  resp_rdata  out  32  raw RAM word at addr[AW+1:2]; loads only, 0 for stores and errors
//  resp_err    out  1   misaligned, out-of-range or reserved size; no RAM write occurred
// BEHAVIOUR
//  Reset values:
//   - State IDLE; resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
//   - RAM contents are not reset.
//  Handshake:
//   - Accept when req_valid && req_ready.
//   - req_ready = (state==IDLE) || (state==RESP && resp_ready).
//   - Once accepted, all request fields are captured; later changes on req_* have no effect.
//  FSM:
//   - IDLE -accept-> WAIT if WAIT_CYCLES>0, else ACCESS.
//   - WAIT counts WAIT_CYCLES cycles, then goes to ACCESS.
//   - ACCESS (1 cycle): RAM read or strobed write; next state RESP.
//   - RESP holds resp_valid with stable data until resp_ready.
//     On resp_ready with a new accept, next state is WAIT/ACCESS; otherwise IDLE.
//  Latency:
//   - Accept at cycle T gives resp_valid high from cycle T+2+WAIT_CYCLES.
//   - With WAIT_CYCLES=0, a back-to-back stream completes one request per 2 cycles.
//  Store strobes (lane = addr[1:0]):
//   - byte: strb = 4'b0001 << lane; wdata = {4{wdata[7:0]}}.
//   - half: strb = 4'b0011 << lane; wdata = {2{wdata[15:0]}}.
//   - word: strb = 4'b1111.
//  Errors, checked at accept:
//   - half with addr[0]!=0, word with addr[1:0]!=0, size==3, or address out of range.
//   - The request still completes through the FSM: resp_err=1, resp_rdata=0, RAM untouched.
//  Stores:
//   - Return resp_valid with resp_rdata=0 so store completion is ordered with loads.
//  Read-after-write:
//   - A load following a store to the same word observes the new data, because the store's ACCESS precedes the load's accept.
//  Reset mid-operation:
//   - Async resetn low drops to IDLE immediately and discards the in-flight request.
//   - A store already past ACCESS remains written; a store not yet in ACCESS is not written.
// STRUCTURE
//  Shared package / header (mycpu.vh):
//   - MEM_SIZE_B/H/W encodings.
//   - State encodings DMR_IDLE/WAIT/ACCESS/RESP.
//  Sub-module dmr_ram:
//   - 2**AW x 32 single-port synchronous RAM with 4-bit byte write strobe and registered read data.
//   - Must be inferable as block RAM.
//  Top level holds FSM, wait counter, request capture register, strobe/lane logic and error checks.
// TESTING
//  1. Store word 0x0000_0010 <- 0xDEADBEEF, then load word 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at T+3 (WAIT_CYCLES=1).
//  2. Store byte 0x13 <- 0x000000AA onto 0x11223344, then load word 0x10 -> 0xAA223344. Store half 0x12 <- 0x5566 -> 0x55663344.
//  3. Load half 0x11, load word 0x12, size=3, and addr=BASE+0x4000 -> resp_err=1, rdata=0; RAM word at 0x10 unchanged.
//  4. Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0. Release with a queued request -> accepted the same cycle.
//  5. WAIT_CYCLES=0 stream of 8 alternating store/load pairs -> every load returns the preceding store's data, one completion per 2 cycles.
//  6. Assert resetn low during WAIT of a store to 0x20 -> resp_valid=0 asynchronously; after release, load 0x20 returns the prior value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings and store lane helpers for the data-memory responder.
package data_mem_responder_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    DMR_IDLE   = 2'd0,
    DMR_WAIT   = 2'd1,
    DMR_ACCESS = 2'd2,
    DMR_RESP   = 2'd3
  } dmr_state_e;

  // Request as captured at accept; strb is already zero for errored requests.
  typedef struct packed {
    logic        wr;
    logic        err;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } dmr_req_t;

  function automatic logic [3:0] dmr_strb(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      MEM_SIZE_B: s = 4'b0001 << lane;
      MEM_SIZE_H: s = 4'b0011 << lane;
      MEM_SIZE_W: s = 4'b1111;
      default:    s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] dmr_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    case (size)
      MEM_SIZE_B: d = {4{wdata[7:0]}};
      MEM_SIZE_H: d = {2{wdata[15:0]}};
      default:    d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic dmr_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'd3) ||
           (size == MEM_SIZE_H && lane[0]) ||
           (size == MEM_SIZE_W && lane != 2'b00);
  endfunction

endpackage

// File: rtl/dmr_ram.sv
// Single-port word RAM with byte write strobes and registered read data.
module dmr_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // Read-first: rdata shows the word as it was before this cycle's write.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: captures a load/store, waits WAIT_CYCLES, accesses the RAM, then holds the response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          AW          = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  dmr_state_e    state;
  dmr_state_e    start_st;
  logic [3:0]    wait_cnt;
  dmr_req_t      cap;
  dmr_req_t      req_cap;
  logic [AW-1:0] cap_idx;
  logic          resp_load;
  logic          accept;
  logic          in_range;
  logic          req_err;
  logic [31:0]   off;
  logic [31:0]   ram_q;

  assign req_ready = (state == DMR_IDLE) || (state == DMR_RESP && resp_ready);
  assign accept    = req_valid && req_ready;
  assign start_st  = (WAIT_CYCLES > 0) ? DMR_WAIT : DMR_ACCESS;

  // Offset from the window base; anything at or past 4*2**AW (including wrap below base) is out of range.
  assign off      = req_addr - BASE_ADDR;
  assign in_range = (off >> (AW + 2)) == 32'd0;
  assign req_err  = dmr_misaligned(req_size, off[1:0]) || !in_range;

  always_comb begin
    req_cap       = '0;
    req_cap.wr    = req_wr;
    req_cap.err   = req_err;
    req_cap.strb  = req_err ? 4'b0000 : dmr_strb(req_size, off[1:0]);
    req_cap.wdata = dmr_wdata(req_size, req_wdata);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= DMR_IDLE;
      wait_cnt   <= '0;
      cap        <= '0;
      cap_idx    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_load  <= 1'b0;
    end else begin
      if (accept) begin
        cap      <= req_cap;
        cap_idx  <= off[AW+1:2];
        wait_cnt <= '0;
      end
      unique case (state)
        DMR_IDLE: if (accept) state <= start_st;
        DMR_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= DMR_ACCESS;
          else                       wait_cnt <= wait_cnt + 4'd1;
        end
        DMR_ACCESS: begin
          state      <= DMR_RESP;
          resp_valid <= 1'b1;
          resp_err   <= cap.err;
          resp_load  <= !cap.wr && !cap.err;
        end
        DMR_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_load  <= 1'b0;
            state      <= accept ? start_st : DMR_IDLE;
          end
        end
        default: state <= DMR_IDLE;
      endcase
    end
  end

  // RAM output register only updates in ACCESS, so it stays stable throughout RESP.
  assign resp_rdata = resp_load ? ram_q : 32'd0;

  dmr_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .en    (state == DMR_ACCESS),
    .we    (cap.wr ? cap.strb : 4'b0000),
    .addr  (cap_idx),
    .wdata (cap.wdata),
    .rdata (ram_q)
  );

endmodule
